uart_tx_param: RTL and testbench
================================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter DATA_W, default 8: data bits per frame, legal range 5..9.
REQ-002 Parameter PARITY, default 0: parity mode; 0 = none, 1 = even, 2 = odd.
REQ-003 Parameter STOP_BITS, default 1: stop bits per frame, legal values 1 or 2.
REQ-004 Parameter BIT_TICKS, default 1: enabled clock cycles per serial bit, legal range 1..65535.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  baud tick / clock enable; bit timing and FSM advance only in cycles with enable=1.
REQ-008 load  input  1  one-cycle request to queue data_in for transmission.
REQ-009 data_in  input  DATA_W  frame payload, sampled in the load cycle.
REQ-010 data_out  output  1  serial line; idle high.
REQ-011 busy  output  1  high while a frame is in progress.
REQ-012 ready  output  1  high when the one-entry holding buffer is empty.
REQ-013 done  output  1  one-cycle pulse on completion of each frame.
REQ-014 error  output  1  one-cycle pulse when a load is dropped.

Function
REQ-015 The FSM SHALL have the states IDLE, START, DATA, PAR, and STOP; PAR is skipped when PARITY=0.
REQ-016 Frame order: start bit 0, data bits LSB first, optional parity bit, then STOP_BITS stop bits of value 1.
REQ-017 Each bit SHALL hold data_out for exactly BIT_TICKS cycles with enable=1; frame length = (1+DATA_W+(PARITY!=0)+STOP_BITS)*BIT_TICKS enabled cycles.
REQ-018 Even parity SHALL make the total count of ones in the data bits plus the parity bit even; odd parity SHALL make that count odd.
REQ-019 load SHALL be accepted regardless of enable, and data_in SHALL be captured in the load cycle.
REQ-020 A load in IDLE SHALL move the FSM to START and set busy=1 with data_out=0 on the next cycle, provided enable=1 on the next cycle; otherwise start is deferred until the first enabled cycle, with data_out held at 1.
REQ-021 A load while busy with the holding buffer empty SHALL store data_in in the holding buffer and set ready=0 on the next cycle.
REQ-022 A load while busy with the holding buffer full SHALL be dropped, pulse error for one cycle on the next cycle, and leave both the frame in progress and the buffered data unchanged.
REQ-023 At the end of the last stop-bit tick with the holding buffer full, the buffered data SHALL move to the shift register, START SHALL begin on the next cycle with no idle bit, busy SHALL stay 1, and ready SHALL return to 1.
REQ-024 At the end of the last stop-bit tick with the holding buffer empty, the FSM SHALL return to IDLE and busy SHALL fall to 0 on the next cycle.
REQ-025 done SHALL pulse for one cycle at every frame end, including back-to-back frames.
REQ-026 A load in the same cycle as a frame end with the buffer full SHALL be accepted into the buffer being drained, with no error.
REQ-027 A load in the same cycle as a frame end with the buffer empty SHALL start the next frame directly, without error.
REQ-028 While enable=0, all state, bit counters, and data_out SHALL be frozen; load, error, and ready SHALL still operate as specified.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 reset=1 at a rising edge SHALL force: state IDLE, data_out=1, busy=0, ready=1, done=0, error=0, holding buffer empty, bit and tick counters at 0.
REQ-031 reset SHALL take priority over load and enable; a load coincident with reset SHALL be discarded.
REQ-032 Reset during a frame SHALL abort the frame, with data_out=1 on the following cycle and no done pulse.

Structure
REQ-033 Shared package uart_pkg SHALL hold the FSM state type and the parity mode constants PAR_NONE, PAR_EVEN, and PAR_ODD.
REQ-034 The bit-period counter SHALL be a sub-module, uart_bit_timer (BIT_TICKS-cycle tick counter with enable and clear); all other logic SHALL stay in uart_tx_param.

Verification
REQ-035 Setup: DATA_W=8, PARITY=1, STOP_BITS=1, BIT_TICKS=1, enable=1. Stimulus: load 0xA5. Response: data_out = 0,1,0,1,0,0,1,0,1,0,1 on consecutive cycles, done pulse after cycle 11, busy falls on the next cycle.
REQ-036 Setup: PARITY=2. Stimulus: load 0x00. Response: parity bit = 1. Setup: PARITY=2. Stimulus: load 0xFF. Response: parity bit = 1. Setup: PARITY=0. Stimulus: any load. Response: frame of 10 bits.
REQ-037 Stimulus: load 0x12, 0x34 during the first frame, then 0x56 while the buffer is full. Response: 0x56 dropped with one error pulse; 0x12 and 0x34 sent back-to-back with no idle gap and two done pulses.
REQ-038 Setup: BIT_TICKS=4, STOP_BITS=2. Stimulus: load 0x3C with enable deasserted for 10 cycles mid-frame. Response: data_out frozen during the stall; frame completes after 44 enabled cycles with correct bits.
REQ-039 Stimulus: load 0x55, then assert reset 4 bits into the frame. Response: data_out=1, busy=0, ready=1 next cycle, no done pulse; a subsequent load 0xAA transmits correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: transmitter FSM states, parity mode encodings and the
// parity helper used when a byte is committed to the shift register.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Payload is zero-extended to 9 bits, so extra zeros never change the result.
    function automatic logic parity_of(input logic [8:0] dat, input int mode);
        return (^dat) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: tick marks the last enabled cycle of each serial bit.
// Latency: tick is combinational from the count and enable; count updates on clk.
// Backpressure: none; enable=0 freezes the count, clear forces it back to zero.
module uart_bit_timer #(
    parameter int BIT_TICKS = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_TICKS - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with a one-entry holding buffer for back-to-back frames.
// Latency: a load in an enabled idle cycle drives the start bit on the next cycle.
// Backpressure: ready=0 while the buffer holds a byte; a load then is dropped with an error pulse.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int BIT_TICKS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    output logic              data_out,
    output logic              busy,
    output logic              ready,
    output logic              done,
    output logic              error
);

    localparam logic [3:0] LAST_DATA = 4'(DATA_W - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] buf_dat;
    logic              buf_full;
    logic              par_r;
    logic [3:0]        bit_cnt;

    logic              timer_en;
    logic              timer_clr;
    logic              tick;
    logic              frame_end;
    logic              launch;
    logic [DATA_W-1:0] launch_dat;
    logic              load_direct;
    logic              load_to_buf;
    logic              load_drop;
    logic              buf_full_nxt;

    assign timer_en  = enable && (state != ST_IDLE);
    assign timer_clr = (state == ST_IDLE);

    uart_bit_timer #(
        .BIT_TICKS(BIT_TICKS)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (timer_en),
        .clear  (timer_clr),
        .tick   (tick)
    );

    // A frame launches from idle or straight off the last stop tick; the buffer
    // always drains first, so a coincident load can refill it in the same cycle.
    always_comb begin
        frame_end    = (state == ST_STOP) && tick && (bit_cnt == LAST_STOP);
        launch       = enable && ((state == ST_IDLE) || frame_end) && (buf_full || load);
        launch_dat   = buf_full ? buf_dat : data_in;
        load_direct  = load && launch && !buf_full;
        load_to_buf  = load && !load_direct && (!buf_full || launch);
        load_drop    = load && !load_direct && buf_full && !launch;
        buf_full_nxt = load_to_buf || (buf_full && !launch);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            buf_dat  <= '0;
            buf_full <= 1'b0;
            par_r    <= 1'b0;
            bit_cnt  <= '0;
            data_out <= 1'b1;
            busy     <= 1'b0;
            ready    <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            done     <= frame_end;
            error    <= load_drop;
            buf_full <= buf_full_nxt;
            ready    <= !buf_full_nxt;
            if (load_to_buf) begin
                buf_dat <= data_in;
            end

            if (launch) begin
                state    <= ST_START;
                shreg    <= launch_dat;
                par_r    <= parity_of(9'(launch_dat), PARITY);
                bit_cnt  <= '0;
                data_out <= 1'b0;
                busy     <= 1'b1;
            end else if (tick) begin
                case (state)
                    ST_START: begin
                        state    <= ST_DATA;
                        bit_cnt  <= '0;
                        data_out <= shreg[0];
                    end
                    ST_DATA: begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            if (PARITY != PAR_NONE) begin
                                state    <= ST_PAR;
                                data_out <= par_r;
                            end else begin
                                state    <= ST_STOP;
                                data_out <= 1'b1;
                            end
                        end else begin
                            bit_cnt  <= bit_cnt + 4'd1;
                            shreg    <= shreg >> 1;
                            data_out <= shreg[1];
                        end
                    end
                    ST_PAR: begin
                        state    <= ST_STOP;
                        bit_cnt  <= '0;
                        data_out <= 1'b1;
                    end
                    ST_STOP: begin
                        if (frame_end) begin
                            state    <= ST_IDLE;
                            bit_cnt  <= '0;
                            data_out <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboarded bench: stimulus queues hand-computed serial frames, a monitor
// captures data_out per enabled busy cycle and compares on every done pulse.
module tb_uart_tx_param;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst  [4];
    logic       en   [4];
    logic       ld   [4];
    logic [7:0] din  [4];
    logic       dout [4];
    logic       bsy  [4];
    logic       rdy  [4];
    logic       dn   [4];
    logic       er   [4];

    // 0: even parity, 1: odd parity, 2: no parity, 3: no parity / 2 stop / 4 ticks
    uart_tx_param #(.DATA_W(8), .PARITY(1), .STOP_BITS(1), .BIT_TICKS(1)) dut0 (
        .clk(clk), .reset(rst[0]), .enable(en[0]), .load(ld[0]), .data_in(din[0]),
        .data_out(dout[0]), .busy(bsy[0]), .ready(rdy[0]), .done(dn[0]), .error(er[0]));
    uart_tx_param #(.DATA_W(8), .PARITY(2), .STOP_BITS(1), .BIT_TICKS(1)) dut1 (
        .clk(clk), .reset(rst[1]), .enable(en[1]), .load(ld[1]), .data_in(din[1]),
        .data_out(dout[1]), .busy(bsy[1]), .ready(rdy[1]), .done(dn[1]), .error(er[1]));
    uart_tx_param #(.DATA_W(8), .PARITY(0), .STOP_BITS(1), .BIT_TICKS(1)) dut2 (
        .clk(clk), .reset(rst[2]), .enable(en[2]), .load(ld[2]), .data_in(din[2]),
        .data_out(dout[2]), .busy(bsy[2]), .ready(rdy[2]), .done(dn[2]), .error(er[2]));
    uart_tx_param #(.DATA_W(8), .PARITY(0), .STOP_BITS(2), .BIT_TICKS(4)) dut3 (
        .clk(clk), .reset(rst[3]), .enable(en[3]), .load(ld[3]), .data_in(din[3]),
        .data_out(dout[3]), .busy(bsy[3]), .ready(rdy[3]), .done(dn[3]), .error(er[3]));

    typedef struct {
        int           inst;
        logic [127:0] bits;
        int           len;
    } exp_t;

    exp_t         sb[$];
    int           checks   = 0;
    int           failures = 0;
    logic [127:0] cap     [4];
    int           cap_len [4];
    int           err_cnt [4];
    int           exp_err [4];

    function automatic logic [127:0] expand(input logic [15:0] fb, input int nbits, input int bt);
        logic [127:0] r;
        r = '0;
        for (int j = nbits - 1; j >= 0; j--)
            for (int k = 0; k < bt; k++)
                r = {r[126:0], fb[j]};
        return r;
    endfunction

    // fb lists the frame bits in line order, first transmitted bit leftmost.
    task automatic push_exp(input int inst, input logic [15:0] fb, input int nbits, input int bt);
        exp_t e;
        e.inst = inst;
        e.bits = expand(fb, nbits, bt);
        e.len  = nbits * bt;
        sb.push_back(e);
    endtask

    task automatic check1(input string name, input logic act, input logic expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %b, expected %b", name, act, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst[i]) begin
                cap[i]     = '0;
                cap_len[i] = 0;
            end else begin
                if (er[i] === 1'b1) err_cnt[i]++;
                if (dn[i] === 1'b1) begin
                    int idx;
                    idx = -1;
                    for (int k = 0; k < sb.size(); k++)
                        if (idx < 0 && sb[k].inst == i) idx = k;
                    checks++;
                    if (idx < 0) begin
                        failures++;
                        $display("FAIL frame_unexpected dut%0d: done pulse with %0d captured samples, expected no frame", i, cap_len[i]);
                    end else begin
                        if (cap_len[i] != sb[idx].len || cap[i] != sb[idx].bits) begin
                            failures++;
                            $display("FAIL frame dut%0d: got %0d samples %h, expected %0d samples %h",
                                     i, cap_len[i], cap[i], sb[idx].len, sb[idx].bits);
                        end
                        sb.delete(idx);
                    end
                    cap[i]     = '0;
                    cap_len[i] = 0;
                end
                if (bsy[i] === 1'b1 && en[i]) begin
                    cap[i] = {cap[i][126:0], dout[i]};
                    cap_len[i]++;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            rst[i] = 1'b1; en[i] = 1'b1; ld[i] = 1'b0; din[i] = 8'h00;
            cap[i] = '0; cap_len[i] = 0; err_cnt[i] = 0; exp_err[i] = 0;
        end
        exp_err[0] = 1;

        // reset state, with a load held high to show it is discarded
        ld[0] = 1'b1; din[0] = 8'hC3;
        step(2);
        check1("reset_data_out", dout[0], 1'b1);
        check1("reset_busy",     bsy[0],  1'b0);
        check1("reset_ready",    rdy[0],  1'b1);
        check1("reset_done",     dn[0],   1'b0);
        check1("reset_error",    er[0],   1'b0);
        check1("reset_data_out_dut3", dout[3], 1'b1);
        ld[0] = 1'b0;
        for (int i = 0; i < 4; i++) rst[i] = 1'b0;
        step(2);
        check1("idle_after_reset_busy", bsy[0], 1'b0);

        // 0xA5, even parity
        push_exp(0, 16'b0_10100101_0_1, 11, 1);
        ld[0] = 1'b1; din[0] = 8'hA5;
        step(1);
        ld[0] = 1'b0;
        check1("a5_first_busy",  bsy[0],  1'b1);
        check1("a5_start_bit",   dout[0], 1'b0);
        step(11);
        check1("a5_done",        dn[0],   1'b1);
        check1("a5_busy_fall",   bsy[0],  1'b0);
        check1("a5_line_idle",   dout[0], 1'b1);
        step(2);

        // 0x12 then 0x34 buffered, 0x56 dropped
        push_exp(0, 16'b0_01001000_0_1, 11, 1);
        push_exp(0, 16'b0_00101100_1_1, 11, 1);
        ld[0] = 1'b1; din[0] = 8'h12;
        step(1);
        ld[0] = 1'b0;
        step(2);
        ld[0] = 1'b1; din[0] = 8'h34;
        step(1);
        ld[0] = 1'b0;
        check1("buf_ready_low", rdy[0], 1'b0);
        step(1);
        ld[0] = 1'b1; din[0] = 8'h56;
        step(1);
        ld[0] = 1'b0;
        check1("drop_error_pulse", er[0],  1'b1);
        check1("drop_ready_low",   rdy[0], 1'b0);
        step(1);
        check1("drop_error_one_cycle", er[0], 1'b0);
        step(5);
        check1("b2b_done1",      dn[0],   1'b1);
        check1("b2b_busy_held",  bsy[0],  1'b1);
        check1("b2b_no_gap",     dout[0], 1'b0);
        check1("b2b_ready_back", rdy[0],  1'b1);
        step(11);
        check1("b2b_done2",      dn[0],   1'b1);
        check1("b2b_busy_fall",  bsy[0],  1'b0);
        step(2);

        // 0x55 aborted by reset four bits in, then 0xAA
        ld[0] = 1'b1; din[0] = 8'h55;
        step(1);
        ld[0] = 1'b0;
        step(4);
        rst[0] = 1'b1;
        step(1);
        check1("abort_data_out", dout[0], 1'b1);
        check1("abort_busy",     bsy[0],  1'b0);
        check1("abort_ready",    rdy[0],  1'b1);
        check1("abort_no_done",  dn[0],   1'b0);
        rst[0] = 1'b0;
        step(1);
        push_exp(0, 16'b0_01010101_0_1, 11, 1);
        ld[0] = 1'b1; din[0] = 8'hAA;
        step(1);
        ld[0] = 1'b0;
        step(14);

        // odd parity on all-zero and all-one payloads
        push_exp(1, 16'b0_00000000_1_1, 11, 1);
        ld[1] = 1'b1; din[1] = 8'h00;
        step(1);
        ld[1] = 1'b0;
        check1("odd00_start_bit", dout[1], 1'b0);
        step(13);
        push_exp(1, 16'b0_11111111_1_1, 11, 1);
        ld[1] = 1'b1; din[1] = 8'hFF;
        step(1);
        ld[1] = 1'b0;
        step(13);

        // no parity, load while enable is low defers the start
        push_exp(2, 16'b0_10000001_1, 10, 1);
        en[2] = 1'b0;
        ld[2] = 1'b1; din[2] = 8'h81;
        step(1);
        ld[2] = 1'b0;
        check1("deferred_line_high", dout[2], 1'b1);
        en[2] = 1'b1;
        step(14);

        // 4 ticks per bit, 2 stop bits, 10-cycle stall mid-frame
        push_exp(3, 16'b0_00111100_1_1, 11, 4);
        ld[3] = 1'b1; din[3] = 8'h3C;
        step(1);
        ld[3] = 1'b0;
        step(20);
        en[3] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check1("stall_data_out", dout[3], 1'b1);
            check1("stall_busy",     bsy[3],  1'b1);
            step(1);
        end
        en[3] = 1'b1;
        step(30);
        check1("stall_frame_over", bsy[3], 1'b0);

        step(3);
        for (int i = 0; i < 4; i++) begin
            int left;
            left = 0;
            foreach (sb[k]) if (sb[k].inst == i) left++;
            checks++;
            if (left != 0) begin
                failures++;
                $display("FAIL frames_missing dut%0d: %0d expected frames never completed, required 0", i, left);
            end
            checks++;
            if (err_cnt[i] != exp_err[i]) begin
                failures++;
                $display("FAIL error_count dut%0d: got %0d pulses, expected %0d", i, err_cnt[i], exp_err[i]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
